// File: rtl/amt_pkg.sv
// Shared definitions for the architectural map table: default sizes, the
// recovery FSM state type and the commit packet layout.
package amt_pkg;

   localparam int AMT_COMMIT_WIDTH  = 4;
   localparam int AMT_NUM_LOG       = 34;
   localparam int AMT_PHYS_W        = 7;
   localparam int AMT_RECOVER_WIDTH = 2;

   // Index width for v entries; never narrower than one bit.
   function automatic int amt_clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return (r == 0) ? 1 : r;
   endfunction

   localparam int AMT_LOG_W = amt_clog2(AMT_NUM_LOG);

   typedef enum logic {
      IDLE = 1'b0,
      WALK = 1'b1
   } amt_state_e;

   typedef struct packed {
      logic [AMT_LOG_W-1:0]  log;
      logic [AMT_PHYS_W-1:0] phys;
   } amt_commit_t;

endpackage

// File: rtl/amt_storage.sv
// Committed logical-to-physical map: flop array with identity reset,
// per-lane write ports and purely combinational read ports.
module amt_storage #(
   parameter int NUM_LOG  = 34,
   parameter int LOG_W    = 6,
   parameter int PHYS_W   = 7,
   parameter int WR_PORTS = 4,
   parameter int RR_PORTS = 2
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [WR_PORTS-1:0]                wr_en_i,
   input  logic [WR_PORTS-1:0][LOG_W-1:0]     wr_log_i,
   input  logic [WR_PORTS-1:0][PHYS_W-1:0]    wr_phys_i,
   input  logic [WR_PORTS-1:0][LOG_W-1:0]     crd_log_i,
   output logic [WR_PORTS-1:0][PHYS_W-1:0]    crd_phys_o,
   input  logic [RR_PORTS-1:0][LOG_W-1:0]     rrd_log_i,
   output logic [RR_PORTS-1:0][PHYS_W-1:0]    rrd_phys_o
);

   logic [NUM_LOG-1:0][PHYS_W-1:0] map_q, map_d;

   // Writers never collide (older duplicates are killed upstream), so
   // port order does not matter here.
   always_comb begin
      map_d = map_q;
      for (int k = 0; k < WR_PORTS; k++)
         if (wr_en_i[k] && (int'(wr_log_i[k]) < NUM_LOG))
            map_d[wr_log_i[k]] = wr_phys_i[k];
      if (reset)
         for (int i = 0; i < NUM_LOG; i++)
            map_d[i] = PHYS_W'(i);
   end

   always_ff @(posedge clk) map_q <= map_d;

   always_comb begin
      crd_phys_o = '0;
      rrd_phys_o = '0;
      for (int k = 0; k < WR_PORTS; k++)
         if (int'(crd_log_i[k]) < NUM_LOG) crd_phys_o[k] = map_q[crd_log_i[k]];
      for (int s = 0; s < RR_PORTS; s++)
         if (int'(rrd_log_i[s]) < NUM_LOG) rrd_phys_o[s] = map_q[rrd_log_i[s]];
   end

endmodule

// File: rtl/arch_map_table_param.sv
// Architectural map table: applies retiring mappings, returns the displaced
// physical register per lane, and streams the table out on recovery.
module arch_map_table_param
   import amt_pkg::*;
#(
   parameter int COMMIT_WIDTH  = AMT_COMMIT_WIDTH,
   parameter int NUM_LOG       = AMT_NUM_LOG,
   parameter int LOG_W         = amt_clog2(NUM_LOG),
   parameter int PHYS_W        = AMT_PHYS_W,
   parameter int RECOVER_WIDTH = AMT_RECOVER_WIDTH
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic [COMMIT_WIDTH-1:0]                 commit_valid_i,
   input  logic [COMMIT_WIDTH-1:0][LOG_W-1:0]      commit_log_i,
   input  logic [COMMIT_WIDTH-1:0][PHYS_W-1:0]     commit_phys_i,
   output logic [COMMIT_WIDTH-1:0]                 release_valid_o,
   output logic [COMMIT_WIDTH-1:0][PHYS_W-1:0]     release_phys_o,
   input  logic                                    recover_i,
   output logic                                    recover_valid_o,
   output logic [RECOVER_WIDTH-1:0][LOG_W-1:0]     recover_log_o,
   output logic [RECOVER_WIDTH-1:0][PHYS_W-1:0]    recover_phys_o,
   output logic                                    recover_busy_o,
   output logic                                    recover_done_o
);

   if (NUM_LOG % RECOVER_WIDTH != 0) begin : g_chk_beats
      $error("NUM_LOG must be a multiple of RECOVER_WIDTH");
   end
   if ((2 ** PHYS_W) < NUM_LOG) begin : g_chk_phys
      $error("PHYS_W too narrow to hold the identity map");
   end

   localparam logic [LOG_W-1:0] LAST_BASE = LOG_W'(NUM_LOG - RECOVER_WIDTH);

   amt_state_e                             state_q, state_d;
   logic [LOG_W-1:0]                       cnt_q, cnt_d;
   logic                                   commit_ok;
   logic [COMMIT_WIDTH-1:0]                kill, wr_en;
   logic [COMMIT_WIDTH-1:0][PHYS_W-1:0]    cur_phys;
   logic [RECOVER_WIDTH-1:0][LOG_W-1:0]    walk_log;
   logic [RECOVER_WIDTH-1:0][PHYS_W-1:0]   walk_phys;

   // A younger lane writing the same register makes this lane's mapping
   // dead on arrival; it frees its own new phys instead.
   always_comb begin
      kill = '0;
      for (int k = 0; k < COMMIT_WIDTH; k++)
         for (int j = k + 1; j < COMMIT_WIDTH; j++)
            if (commit_valid_i[j] && (commit_log_i[j] == commit_log_i[k]))
               kill[k] = 1'b1;
   end

   assign commit_ok       = (state_q == IDLE) && !reset;
   assign wr_en           = commit_valid_i & ~kill & {COMMIT_WIDTH{commit_ok}};
   assign release_valid_o = commit_valid_i & {COMMIT_WIDTH{commit_ok}};

   always_comb begin
      release_phys_o = '0;
      for (int k = 0; k < COMMIT_WIDTH; k++)
         release_phys_o[k] = kill[k] ? commit_phys_i[k] : cur_phys[k];
   end

   always_comb begin
      walk_log = '0;
      for (int s = 0; s < RECOVER_WIDTH; s++)
         walk_log[s] = cnt_q + LOG_W'(s);
   end

   amt_storage #(
      .NUM_LOG  (NUM_LOG),
      .LOG_W    (LOG_W),
      .PHYS_W   (PHYS_W),
      .WR_PORTS (COMMIT_WIDTH),
      .RR_PORTS (RECOVER_WIDTH)
   ) u_storage (
      .clk        (clk),
      .reset      (reset),
      .wr_en_i    (wr_en),
      .wr_log_i   (commit_log_i),
      .wr_phys_i  (commit_phys_i),
      .crd_log_i  (commit_log_i),
      .crd_phys_o (cur_phys),
      .rrd_log_i  (walk_log),
      .rrd_phys_o (walk_phys)
   );

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      recover_valid_o = 1'b0;
      recover_busy_o  = 1'b0;
      recover_done_o  = 1'b0;
      recover_log_o   = '0;
      recover_phys_o  = '0;
      case (state_q)
         IDLE: begin
            if (recover_i) begin
               state_d = WALK;
               cnt_d   = '0;
            end
         end
         WALK: begin
            recover_valid_o = 1'b1;
            recover_busy_o  = 1'b1;
            recover_log_o   = walk_log;
            recover_phys_o  = walk_phys;
            if (cnt_q == LAST_BASE) begin
               recover_done_o = 1'b1;
               state_d        = IDLE;
               cnt_d          = '0;
            end else begin
               cnt_d = cnt_q + LOG_W'(RECOVER_WIDTH);
            end
         end
         default: state_d = IDLE;
      endcase
      if (reset) begin
         state_d = IDLE;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
   end

   // Commits during a walk are dropped; upstream should never send them.
   always_ff @(posedge clk) begin
      if (!reset && state_q == WALK)
         a_no_commit_in_walk: assert (commit_valid_i == '0)
            else $warning("commit_valid_i asserted during recovery walk; commits dropped");
   end

endmodule

// File: tb/tb_arch_map_table_param.sv
// Bench for arch_map_table_param: directed vector table, multi-cycle walk
// sequences and randomized commits against an array-based reference model.
module tb_arch_map_table_param;
   import amt_pkg::*;

   localparam int CW    = AMT_COMMIT_WIDTH;
   localparam int NL    = AMT_NUM_LOG;
   localparam int LW    = AMT_LOG_W;
   localparam int PW    = AMT_PHYS_W;
   localparam int RW    = AMT_RECOVER_WIDTH;
   localparam int BEATS = NL / RW;

   logic                      clk = 1'b0;
   logic                      reset;
   logic [CW-1:0]             commit_valid_i;
   logic [CW-1:0][LW-1:0]     commit_log_i;
   logic [CW-1:0][PW-1:0]     commit_phys_i;
   logic [CW-1:0]             release_valid_o;
   logic [CW-1:0][PW-1:0]     release_phys_o;
   logic                      recover_i;
   logic                      recover_valid_o;
   logic [RW-1:0][LW-1:0]     recover_log_o;
   logic [RW-1:0][PW-1:0]     recover_phys_o;
   logic                      recover_busy_o;
   logic                      recover_done_o;

   arch_map_table_param #(
      .COMMIT_WIDTH (CW), .NUM_LOG (NL), .LOG_W (LW), .PHYS_W (PW), .RECOVER_WIDTH (RW)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .commit_valid_i  (commit_valid_i),
      .commit_log_i    (commit_log_i),
      .commit_phys_i   (commit_phys_i),
      .release_valid_o (release_valid_o),
      .release_phys_o  (release_phys_o),
      .recover_i       (recover_i),
      .recover_valid_o (recover_valid_o),
      .recover_log_o   (recover_log_o),
      .recover_phys_o  (recover_phys_o),
      .recover_busy_o  (recover_busy_o),
      .recover_done_o  (recover_done_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   int model[NL];

   typedef struct {
      logic [CW-1:0]            v;
      amt_commit_t [CW-1:0]     c;
      logic [CW-1:0][PW-1:0]    exp_rel;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   function automatic amt_commit_t mk(input int l, input int p);
      amt_commit_t r;
      r.log  = LW'(l);
      r.phys = PW'(p);
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NL; i++) model[i] = i;
   endtask

   // Spec rule: a lane shadowed by a younger same-destination lane frees its
   // own phys; otherwise it frees the current mapping. Then retire in order.
   task automatic model_commit(input logic [CW-1:0] v, input amt_commit_t [CW-1:0] c,
                               output int rel[CW]);
      for (int k = 0; k < CW; k++) begin
         rel[k] = model[c[k].log];
         for (int j = k + 1; j < CW; j++)
            if (v[j] && c[j].log == c[k].log) rel[k] = c[k].phys;
      end
      for (int k = 0; k < CW; k++)
         if (v[k]) model[c[k].log] = c[k].phys;
   endtask

   task automatic drive(input logic [CW-1:0] v, input amt_commit_t [CW-1:0] c);
      commit_valid_i = v;
      for (int k = 0; k < CW; k++) begin
         commit_log_i[k]  = c[k].log;
         commit_phys_i[k] = c[k].phys;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_walk();
      recover_i = 1'b1;
      step();
      recover_i = 1'b0;
   endtask

   // Entered in the cycle showing beat 0. Negative beat numbers disable the
   // respective injection.
   task automatic run_walk(input int viol_b, input int rec_b, input int rst_b);
      for (int b = 0; b < BEATS; b++) begin
         if (b == viol_b) begin
            commit_valid_i   = 4'b0001;
            commit_log_i[0]  = LW'(12);
            commit_phys_i[0] = PW'(99);
         end
         if (b == rec_b) recover_i = 1'b1;
         if (b == rst_b) reset = 1'b1;
         #1;
         if (b != rst_b) begin
            chk($sformatf("walk_valid_b%0d", b), recover_valid_o, 1);
            chk($sformatf("walk_busy_b%0d", b), recover_busy_o, 1);
            chk($sformatf("walk_done_b%0d", b), recover_done_o, (b == BEATS - 1) ? 1 : 0);
            for (int s = 0; s < RW; s++) begin
               chk($sformatf("walk_log_b%0d_s%0d", b, s), recover_log_o[s], b * RW + s);
               chk($sformatf("walk_phys_b%0d_s%0d", b, s), recover_phys_o[s], model[b * RW + s]);
            end
         end
         if (b == viol_b) chk("viol_release_valid", release_valid_o, 0);
         step();
         commit_valid_i = '0;
         recover_i      = 1'b0;
         if (b == rst_b) begin
            reset = 1'b0;
            model_reset();
            chk("rst_walk_busy", recover_busy_o, 0);
            chk("rst_walk_valid", recover_valid_o, 0);
            for (int i = 0; i < 3; i++) begin
               chk("rst_walk_no_done", recover_done_o, 0);
               step();
            end
            return;
         end
      end
      chk("post_walk_busy", recover_busy_o, 0);
      chk("post_walk_valid", recover_valid_o, 0);
      chk("post_walk_done", recover_done_o, 0);
   endtask

   initial begin
      amt_commit_t [CW-1:0] c;
      logic [CW-1:0]        v;
      int                   rel[CW];

      reset          = 1'b1;
      recover_i      = 1'b0;
      commit_valid_i = '0;
      commit_log_i   = '0;
      commit_phys_i  = '0;
      model_reset();

      // Directed vectors, applied in order from the identity map.
      c = {mk(9, 99), mk(9, 99), mk(9, 99), mk(5, 40)};
      vecs[0] = '{v: 4'b0001, c: c, exp_rel: {7'd0, 7'd0, 7'd0, 7'd5}};
      c = {mk(9, 99), mk(9, 99), mk(9, 99), mk(5, 41)};
      vecs[1] = '{v: 4'b0001, c: c, exp_rel: {7'd0, 7'd0, 7'd0, 7'd40}};
      c = {mk(7, 52), mk(9, 99), mk(7, 51), mk(7, 50)};
      vecs[2] = '{v: 4'b1011, c: c, exp_rel: {7'd7, 7'd0, 7'd51, 7'd50}};
      c = {mk(5, 13), mk(1, 12), mk(2, 11), mk(1, 10)};
      vecs[3] = '{v: 4'b1111, c: c, exp_rel: {7'd41, 7'd1, 7'd2, 7'd10}};
      c = {mk(3, 1), mk(3, 2), mk(3, 3), mk(3, 4)};
      vecs[4] = '{v: 4'b0000, c: c, exp_rel: {7'd0, 7'd0, 7'd0, 7'd0}};
      c = {mk(7, 20), mk(0, 0), mk(7, 21), mk(0, 0)};
      vecs[5] = '{v: 4'b1010, c: c, exp_rel: {7'd52, 7'd0, 7'd21, 7'd0}};

      step();
      step();
      chk("rst_recover_valid", recover_valid_o, 0);
      chk("rst_recover_busy", recover_busy_o, 0);
      chk("rst_recover_done", recover_done_o, 0);
      chk("rst_release_valid", release_valid_o, 0);
      chk("rst_recover_log", recover_log_o, 0);
      chk("rst_recover_phys", recover_phys_o, 0);
      reset = 1'b0;

      start_walk();
      run_walk(-1, -1, -1);

      foreach (vecs[i]) begin
         drive(vecs[i].v, vecs[i].c);
         #1;
         chk($sformatf("vec%0d_rel_valid", i), release_valid_o, vecs[i].v);
         for (int k = 0; k < CW; k++)
            if (vecs[i].v[k])
               chk($sformatf("vec%0d_rel_phys_l%0d", i, k), release_phys_o[k], vecs[i].exp_rel[k]);
         model_commit(vecs[i].v, vecs[i].c, rel);
         step();
      end
      commit_valid_i = '0;
      start_walk();
      run_walk(-1, -1, -1);

      // Commits in the same cycle as the recovery request are visible to the walk.
      reset = 1'b1;
      step();
      reset = 1'b0;
      model_reset();
      c = {mk(0, 0), mk(4, 61), mk(0, 0), mk(3, 60)};
      v = 4'b0101;
      drive(v, c);
      recover_i = 1'b1;
      #1;
      chk("rc_rel_valid", release_valid_o, v);
      chk("rc_rel_l0", release_phys_o[0], 3);
      chk("rc_rel_l2", release_phys_o[2], 4);
      model_commit(v, c, rel);
      step();
      recover_i      = 1'b0;
      commit_valid_i = '0;
      run_walk(-1, -1, -1);

      // Illegal commit at beat 5 and re-request at beat 8, then confirm the table.
      start_walk();
      run_walk(5, 8, -1);
      start_walk();
      run_walk(-1, -1, -1);

      // Reset mid-walk, then a clean walk shows the identity map.
      start_walk();
      run_walk(-1, -1, 3);
      start_walk();
      run_walk(-1, -1, -1);

      // Randomized commits with periodic recoveries.
      for (int it = 0; it < 400; it++) begin
         v = CW'($urandom_range(0, (1 << CW) - 1));
         for (int k = 0; k < CW; k++)
            c[k] = mk((it % 2 == 1) ? $urandom_range(0, NL - 1) : $urandom_range(0, 5),
                      $urandom_range(0, (1 << PW) - 1));
         drive(v, c);
         if (it % 50 == 49) recover_i = 1'b1;
         #1;
         chk("rnd_rel_valid", release_valid_o, v);
         model_commit(v, c, rel);
         for (int k = 0; k < CW; k++)
            if (v[k]) chk($sformatf("rnd%0d_rel_l%0d", it, k), release_phys_o[k], rel[k]);
         step();
         commit_valid_i = '0;
         if (recover_i) begin
            recover_i = 1'b0;
            run_walk(-1, -1, -1);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
